// File: rtl/mem_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_pkg
// Shared types for the L1 -> LLC request arbiter: address/data widths, the
// load/store opcode and the arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package mem_req_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Scans requesters starting one past the
// previous winner and wrapping, so whoever was granted last has the lowest
// priority next time.
//
// Ports
//   req_valid   in   per-requester request valid
//   last_grant  in   index of the previous winner
//   grant       out  one-hot grant (zero when nothing is valid)
//   grant_idx   out  binary index of the winner
//   any_valid   out  at least one requester is valid
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  // The first hit wins; any_valid doubles as the "already found" flag so
  // later candidates in the scan cannot overwrite it.
  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!any_valid && req_valid[cand]) begin
        any_valid   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
// Arbitrates NUM_REQ L1 requesters (L1I = 0, L1D = 1 by default) onto a single
// LLC request port with one transaction outstanding at a time. The response
// is routed back as a one-cycle pulse to the requester that owns it.
//
// Ports
//   clk_in, rst_in             clock, synchronous active-high reset
//   cs_N_in                    active-low chip select; when high all outputs
//                              float and every bit of state holds
//   req_valid_in/req_ready_out per-requester handshake (ready one-hot or 0)
//   req_op_in/addr_in/data_in  per-requester request fields
//   rsp_valid_out/rsp_data_out per-requester response pulse, shared data
//   llc_valid_out/llc_ready_in downstream request handshake
//   llc_op/addr/data_out       downstream request fields (mem_op_e encoding
//                              on llc_op_out)
//   llc_rsp_valid_in/data_in   downstream response (one per request)
// ---------------------------------------------------------------------------
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cs_N_in,
  input  logic [NUM_REQ-1:0]    req_valid_in,
  output logic [NUM_REQ-1:0]    req_ready_out,
  input  mem_op_e [NUM_REQ-1:0] req_op_in,
  input  addr_t [NUM_REQ-1:0]   req_addr_in,
  input  data_t [NUM_REQ-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]    rsp_valid_out,
  output data_t                 rsp_data_out,
  output logic                  llc_valid_out,
  input  logic                  llc_ready_in,
  output logic                  llc_op_out,
  output addr_t                 llc_addr_out,
  output data_t                 llc_data_out,
  input  logic                  llc_rsp_valid_in,
  input  data_t                 llc_rsp_data_in
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     owner_id;
  mem_op_e              lat_op;
  addr_t                lat_addr;
  data_t                lat_data;
  data_t                rsp_data_q;
  logic                 llc_valid_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_valid;
  logic                 accept;
  logic [NUM_REQ-1:0]   ready_int;
  mem_op_e              llc_op_int;
  addr_t                llc_addr_int;
  data_t                llc_data_int;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_valid  (req_valid_in),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  // Ready is combinational so the winner sees its accept in the same cycle.
  // It is suppressed during reset because reset wins over the accept edge.
  always_comb begin
    accept    = (state == ST_IDLE) && any_valid && !rst_in && !cs_N_in;
    ready_int = accept ? grant : '0;
  end

  // Single FSM with registered llc_valid / rsp_valid. Deselecting the chip
  // freezes everything, including the response capture in WAIT.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      owner_id    <= '0;
      lat_op      <= OP_LOAD;
      lat_addr    <= '0;
      lat_data    <= '0;
      rsp_data_q  <= '0;
      llc_valid_q <= 1'b0;
      rsp_valid_q <= '0;
    end else if (!cs_N_in) begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            lat_op      <= req_op_in[grant_idx];
            lat_addr    <= req_addr_in[grant_idx];
            lat_data    <= req_data_in[grant_idx];
            owner_id    <= grant_idx;
            last_grant  <= grant_idx;
            llc_valid_q <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (llc_ready_in) begin
            llc_valid_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (llc_rsp_valid_in) begin
            rsp_data_q  <= llc_rsp_data_in;
            rsp_valid_q <= NUM_REQ'(1) << owner_id;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_data_q  <= '0;
          rsp_valid_q <= '0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Downstream fields are zeroed whenever no request is being offered.
  always_comb begin
    llc_op_int   = llc_valid_q ? lat_op   : OP_LOAD;
    llc_addr_int = llc_valid_q ? lat_addr : '0;
    llc_data_int = llc_valid_q ? lat_data : '0;
  end

  assign req_ready_out = cs_N_in ? 'z : ready_int;
  assign rsp_valid_out = cs_N_in ? 'z : rsp_valid_q;
  assign rsp_data_out  = cs_N_in ? 'z : rsp_data_q;
  assign llc_valid_out = cs_N_in ? 1'bz : llc_valid_q;
  assign llc_op_out    = cs_N_in ? 1'bz : llc_op_int;
  assign llc_addr_out  = cs_N_in ? 'z : llc_addr_int;
  assign llc_data_out  = cs_N_in ? 'z : llc_data_int;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed and randomized transactions against a round-robin reference that
// tracks only the last winner and the expected per-transaction timeline.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int N = 2;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           cs_N_in;
  logic [N-1:0]   req_valid_in;
  logic [N-1:0]   req_ready_out;
  mem_op_e [N-1:0] req_op_in;
  addr_t [N-1:0]  req_addr_in;
  data_t [N-1:0]  req_data_in;
  logic [N-1:0]   rsp_valid_out;
  data_t          rsp_data_out;
  logic           llc_valid_out;
  logic           llc_ready_in;
  logic           llc_op_out;
  addr_t          llc_addr_out;
  data_t          llc_data_out;
  logic           llc_rsp_valid_in;
  data_t          llc_rsp_data_in;

  int      checks = 0;
  int      errors = 0;
  int      m_last;
  mem_op_e f_op   [N];
  addr_t   f_addr [N];
  data_t   f_data [N];

  always #5 clk_in = ~clk_in;

  mem_req_arbiter #(.NUM_REQ(N)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .cs_N_in          (cs_N_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_op_in        (req_op_in),
    .req_addr_in      (req_addr_in),
    .req_data_in      (req_data_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_data_out     (rsp_data_out),
    .llc_valid_out    (llc_valid_out),
    .llc_ready_in     (llc_ready_in),
    .llc_op_out       (llc_op_out),
    .llc_addr_out     (llc_addr_out),
    .llc_data_out     (llc_data_out),
    .llc_rsp_valid_in (llc_rsp_valid_in),
    .llc_rsp_data_in  (llc_rsp_data_in)
  );

  // Reference round-robin: first valid requester after the previous winner.
  function automatic int modelPick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oneHot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // While deselected the output floats, so it must never read as driven high.
  task automatic checkNotDriven(input string tag, input logic obs);
    checks++;
    assert (obs !== 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=not 1", tag, obs);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic rdy, input logic rv,
                               input data_t rdata, input logic csn, input logic rst);
    req_valid_in     = valid;
    llc_ready_in     = rdy;
    llc_rsp_valid_in = rv;
    llc_rsp_data_in  = rdata;
    cs_N_in          = csn;
    rst_in           = rst;
    for (int i = 0; i < N; i++) begin
      req_op_in[i]   = f_op[i];
      req_addr_in[i] = f_addr[i];
      req_data_in[i] = f_data[i];
    end
    #1;
  endtask

  task automatic randomFields();
    for (int i = 0; i < N; i++) begin
      f_op[i]   = ($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD;
      f_addr[i] = $urandom;
      f_data[i] = $urandom;
    end
  endtask

  // One full transaction starting in IDLE. Request fields are re-randomized
  // right after the accept so the downstream fields must come from the latch.
  task automatic runTxn(input logic [N-1:0] mask, input int stall, input int gap,
                        input data_t rdata, input int cs_pause, input string tag);
    int      w;
    mem_op_e e_op;
    addr_t   e_addr;
    data_t   e_data;
    stepCycle();
    applyStimulus(mask, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    w = modelPick(mask);
    checkOutput({tag, ".ready"}, 64'(req_ready_out), 64'(oneHot(w)));
    if (w < 0) return;
    m_last = w;
    e_op   = f_op[w];
    e_addr = f_addr[w];
    e_data = f_data[w];
    randomFields();
    for (int p = 0; p < cs_pause; p++) begin
      stepCycle();
      applyStimulus(mask, 1'b1, 1'b1, data_t'($urandom), 1'b1, 1'b0);
      checkNotDriven({tag, ".cs_llc_valid"}, llc_valid_out);
    end
    for (int s = 0; s <= stall; s++) begin
      stepCycle();
      applyStimulus(mask, (s == stall), 1'b0, '0, 1'b0, 1'b0);
      checkOutput({tag, ".llc_valid"}, 64'(llc_valid_out), 64'(1));
      checkOutput({tag, ".llc_addr"}, 64'(llc_addr_out), 64'(e_addr));
      checkOutput({tag, ".llc_data"}, 64'(llc_data_out), 64'(e_data));
      checkOutput({tag, ".llc_op"}, 64'(llc_op_out), 64'(e_op));
      checkOutput({tag, ".issue_ready"}, 64'(req_ready_out), 64'(0));
    end
    for (int g = 0; g <= gap; g++) begin
      stepCycle();
      applyStimulus(mask, 1'b0, (g == gap), rdata, 1'b0, 1'b0);
      checkOutput({tag, ".wait_llc_valid"}, 64'(llc_valid_out), 64'(0));
      checkOutput({tag, ".wait_llc_addr"}, 64'(llc_addr_out), 64'(0));
      checkOutput({tag, ".wait_rsp_valid"}, 64'(rsp_valid_out), 64'(0));
      checkOutput({tag, ".wait_ready"}, 64'(req_ready_out), 64'(0));
    end
    stepCycle();
    applyStimulus(mask, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid_out), 64'(oneHot(w)));
    checkOutput({tag, ".rsp_data"}, 64'(rsp_data_out), 64'(rdata));
    checkOutput({tag, ".resp_ready"}, 64'(req_ready_out), 64'(0));
  endtask

  initial begin
    int w;
    randomFields();
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset with chip selected, then everything must read zero.
    stepCycle();
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    m_last = N - 1;
    checkOutput("reset.ready", 64'(req_ready_out), 64'(0));
    checkOutput("reset.rsp_valid", 64'(rsp_valid_out), 64'(0));
    checkOutput("reset.rsp_data", 64'(rsp_data_out), 64'(0));
    checkOutput("reset.llc_valid", 64'(llc_valid_out), 64'(0));
    checkOutput("reset.llc_addr", 64'(llc_addr_out), 64'(0));

    // Both requesters held valid: grants alternate starting with 0.
    for (int t = 0; t < 4; t++) begin
      randomFields();
      runTxn(2'b11, 0, 0, data_t'($urandom), 0, "alt");
      checkOutput("alt.winner", 64'(m_last), 64'(t % 2));
    end

    // Requester 1 load with a three-cycle LLC stall.
    randomFields();
    f_op[1]   = OP_LOAD;
    f_addr[1] = 32'h40;
    runTxn(2'b10, 3, 0, 32'hDEAD, 0, "stall");

    // Zero-stall store from requester 0.
    randomFields();
    f_op[0]   = OP_STORE;
    f_data[0] = 32'h1234;
    runTxn(2'b01, 0, 0, 32'hBEEF, 0, "fast");

    // Spurious LLC response while idle is dropped.
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      applyStimulus('0, 1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0);
      checkOutput("spur.rsp_valid", 64'(rsp_valid_out), 64'(0));
      checkOutput("spur.llc_valid", 64'(llc_valid_out), 64'(0));
    end
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("spur.after_rsp_valid", 64'(rsp_valid_out), 64'(0));
    randomFields();
    runTxn(2'b10, 1, 1, data_t'($urandom), 0, "spur_txn");

    // Chip deselected for two cycles during ISSUE.
    randomFields();
    runTxn(2'b11, 1, 0, data_t'($urandom), 2, "cs");

    // Reset while waiting for the LLC; the late response must be dropped.
    randomFields();
    stepCycle();
    applyStimulus(2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    w = modelPick(2'b10);
    checkOutput("rstw.ready", 64'(req_ready_out), 64'(oneHot(w)));
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("rstw.llc_valid", 64'(llc_valid_out), 64'(1));
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("rstw.wait_llc_valid", 64'(llc_valid_out), 64'(0));
    stepCycle();
    applyStimulus('0, 1'b0, 1'b1, 32'hCAFE, 1'b0, 1'b0);
    m_last = N - 1;
    checkOutput("rstw.post_rsp_valid", 64'(rsp_valid_out), 64'(0));
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("rstw.late_rsp_valid", 64'(rsp_valid_out), 64'(0));
    checkOutput("rstw.late_rsp_data", 64'(rsp_data_out), 64'(0));
    randomFields();
    runTxn(2'b11, 0, 0, data_t'($urandom), 0, "rstw_next");
    checkOutput("rstw.next_winner", 64'(m_last), 64'(0));

    // Randomized traffic against the reference.
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(0, 3));
      randomFields();
      runTxn(mask, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             data_t'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
